writeback_arbiter: RTL and testbench

- Drives the single register-file write port (writeAddress/writeEnable/writeData) from two producers: the ALU result path and the load-return path.
- ALU results have no backpressure. Load returns use a valid/ready handshake and are buffered in a small in-order FIFO.
- Enforces write-after-write ordering: a younger ALU write to rd cancels older queued load writes to the same rd.
- Publishes a pending-load mask for the hazard unit.

---
 rtl/writeback_arbiter.sv | 137 +++++++++++++
 tb/tb_writeback_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: drives the single register-file write port from the ALU
// result path (no backpressure, highest priority) and the load-return path
// (valid/ready, buffered in an in-order FIFO). A younger ALU write kills any
// queued load writes to the same register, and a pending-load mask is
// published for the hazard unit.
module writeback_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aluValid,
  input  logic [4:0]               aluRd,
  input  logic [XLEN-1:0]          aluData,
  input  logic                     loadValid,
  output logic                     loadReady,
  input  logic [4:0]               loadRd,
  input  logic [XLEN-1:0]          loadData,
  output logic [4:0]               writeAddress,
  output logic                     writeEnable,
  output logic [XLEN-1:0]          writeData,
  output logic [31:0]              pendingMask,
  output logic [$clog2(DEPTH):0]   fifoCount
);

  localparam int unsigned AW = $clog2(DEPTH);

  // FIFO storage; only the live bits need reset, payload is qualified by them
  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [AW-1:0]   rptr_q, wptr_q;
  logic [AW:0]     count_q;

  logic            accept, alu_sel, fifo_empty, pop, bypass, push, head_live;
  logic [DEPTH-1:0] live_n;
  logic [4:0]      rd_n   [DEPTH];
  logic [31:0]     mask_n;
  logic [AW:0]     count_n;

  assign loadReady  = (count_q < (AW+1)'(DEPTH));
  assign accept     = loadValid && loadReady;
  assign alu_sel    = aluValid && (aluRd != '0);
  assign fifo_empty = (count_q == '0);
  assign pop        = !alu_sel && !fifo_empty;
  assign bypass     = !alu_sel && fifo_empty && accept && (loadRd != '0);
  // a same-cycle load to the ALU's rd is older, so it is consumed and dropped
  assign push       = accept && (loadRd != '0) && !bypass &&
                      !(alu_sel && (loadRd == aluRd));
  assign head_live  = live_q[rptr_q];

  // Next FIFO live/rd view: WAW kill, pop clear, then tail push
  always_comb begin
    live_n = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rd_n[i] = rd_q[i];
      if (alu_sel && (rd_q[i] == aluRd)) live_n[i] = 1'b0;
    end
    if (pop) live_n[rptr_q] = 1'b0;
    if (push) begin
      live_n[wptr_q] = 1'b1;
      rd_n[wptr_q]   = loadRd;
    end
  end

  // Pending mask built from the post-update FIFO state
  always_comb begin
    mask_n = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_n[i]) mask_n[rd_n[i]] = 1'b1;
    end
  end

  // Occupancy update; killed entries still occupy a slot until popped
  always_comb begin
    count_n = count_q;
    case ({push, pop})
      2'b10:   count_n = count_q + (AW+1)'(1);
      2'b01:   count_n = count_q - (AW+1)'(1);
      default: count_n = count_q;
    endcase
  end

  // Payload capture at the tail on push
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wptr_q]   <= loadRd;
      data_q[wptr_q] <= loadData;
    end
  end

  // Control state: pointers, count, live bits, mask
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q      <= '0;
      wptr_q      <= '0;
      count_q     <= '0;
      live_q      <= '0;
      pendingMask <= '0;
    end else begin
      if (pop)  rptr_q <= rptr_q + AW'(1);
      if (push) wptr_q <= wptr_q + AW'(1);
      count_q     <= count_n;
      live_q      <= live_n;
      pendingMask <= mask_n;
    end
  end

  // Registered write port; address/data hold when nothing is written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeEnable  <= 1'b0;
      writeAddress <= '0;
      writeData    <= '0;
    end else if (alu_sel) begin
      writeEnable  <= 1'b1;
      writeAddress <= aluRd;
      writeData    <= aluData;
    end else if (pop) begin
      // a killed head still spends the cycle, with the port idle
      writeEnable <= head_live;
      if (head_live) begin
        writeAddress <= rd_q[rptr_q];
        writeData    <= data_q[rptr_q];
      end
    end else if (bypass) begin
      writeEnable  <= 1'b1;
      writeAddress <= loadRd;
      writeData    <= loadData;
    end else begin
      writeEnable <= 1'b0;
    end
  end

  assign fifoCount = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based model of the writeback rules and a model register file.
module tb_writeback_arbiter;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             aluValid = 1'b0;
  logic [4:0]       aluRd = '0;
  logic [XLEN-1:0]  aluData = '0;
  logic             loadValid = 1'b0;
  logic             loadReady;
  logic [4:0]       loadRd = '0;
  logic [XLEN-1:0]  loadData = '0;
  logic [4:0]       writeAddress;
  logic             writeEnable;
  logic [XLEN-1:0]  writeData;
  logic [31:0]      pendingMask;
  logic [$clog2(DEPTH):0] fifoCount;

  writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData),
    .loadValid(loadValid), .loadReady(loadReady), .loadRd(loadRd), .loadData(loadData),
    .writeAddress(writeAddress), .writeEnable(writeEnable), .writeData(writeData),
    .pendingMask(pendingMask), .fifoCount(fifoCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    bit              live;
  } ent_t;

  ent_t            q[$];
  bit              e_we = 1'b0;
  logic [4:0]      e_addr = '0;
  logic [XLEN-1:0] e_data = '0;
  bit              mdl_acc = 1'b0;
  logic [XLEN-1:0] mrf [32];
  logic [XLEN-1:0] drf [32];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  // Called at negedge: compare port state and commit the capture to both register files
  task automatic check_outputs();
    check("writeEnable", writeEnable, e_we);
    check("writeAddress", writeAddress, e_addr);
    check("writeData", writeData, e_data);
    check("fifoCount", fifoCount, q.size());
    check("pendingMask", pendingMask, model_mask());
    if (e_we) mrf[e_addr] = e_data;
    if (writeEnable === 1'b1) drf[writeAddress] = writeData;
  endtask

  // Applies the writeback rules to the inputs presented for the coming posedge
  task automatic model_step();
    bit ready, acc, alu, byp;
    ent_t h;
    ready = (q.size() < DEPTH);
    acc   = loadValid && ready;
    alu   = aluValid && (aluRd != 0);
    byp   = 1'b0;
    mdl_acc = acc;
    if (alu) begin
      e_we = 1'b1; e_addr = aluRd; e_data = aluData;
      foreach (q[i]) if (q[i].rd == aluRd) q[i].live = 1'b0;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      e_we = h.live;
      if (h.live) begin e_addr = h.rd; e_data = h.data; end
    end else if (acc && loadRd != 0) begin
      byp = 1'b1;
      e_we = 1'b1; e_addr = loadRd; e_data = loadData;
    end else begin
      e_we = 1'b0;
    end
    if (acc && loadRd != 0 && !byp && !(alu && loadRd == aluRd))
      q.push_back('{rd: loadRd, data: loadData, live: 1'b1});
  endtask

  task automatic step(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld);
    @(negedge clk);
    check_outputs();
    aluValid = av; aluRd = ard; aluData = ad;
    loadValid = lv; loadRd = lrd; loadData = ld;
    check("loadReady", loadReady, (q.size() < DEPTH));
    model_step();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
  endtask

  bit              got12;
  bit              plv;
  logic [4:0]      plrd;
  logic [XLEN-1:0] pld;

  initial begin
    for (int i = 0; i < 32; i++) begin mrf[i] = '0; drf[i] = '0; end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // ALU write, then port idles with address/data held
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0);
    @(posedge clk); #1;
    check("alu_we", writeEnable, 1);
    check("alu_addr", writeAddress, 5);
    check("alu_data", writeData, 32'hDEADBEEF);
    idle();
    @(posedge clk); #1;
    check("hold_we", writeEnable, 0);
    check("hold_addr", writeAddress, 5);
    check("hold_data", writeData, 32'hDEADBEEF);

    // Bypass on empty FIFO
    step(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h12345678);
    @(posedge clk); #1;
    check("byp_we", writeEnable, 1);
    check("byp_addr", writeAddress, 7);
    check("byp_data", writeData, 32'h12345678);
    check("byp_count", fifoCount, 0);

    // Fill under continuous ALU traffic; fifth load waits for space
    for (int i = 0; i < 6; i++)
      step(1'b1, 5'(i + 1), 32'(i), 1'b1, (i < 4) ? 5'(8 + i) : 5'd12,
           (i < 4) ? 32'h1000 + 32'(8 + i) : 32'h100C);
    @(posedge clk); #1;
    check("full_count", fifoCount, 4);
    check("full_mask", pendingMask, 32'h0000_0F00);
    check("full_ready", loadReady, 0);
    got12 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 5'd0, '0, !got12, 5'd12, 32'h100C);
      if (mdl_acc && loadRd == 5'd12) got12 = 1'b1;
    end
    check("load12_accepted", got12, 1);
    idle(); idle();

    // WAW kill of a queued load
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    step(1'b1, 5'd3, 32'hA, 1'b0, 5'd0, '0);
    @(posedge clk); #1;
    check("kill_mask3", pendingMask[3], 0);
    check("kill_count", fifoCount, 1);
    idle();
    @(posedge clk); #1;
    check("stale_pop_we", writeEnable, 0);
    idle(); idle();
    check("x3_final", drf[3], 32'hA);

    // Same-cycle ALU and load to the same rd
    step(1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2);
    @(posedge clk); #1;
    check("same_rd_count", fifoCount, 0);
    check("same_rd_data", writeData, 1);
    idle(); idle();
    check("x4_final", drf[4], 1);

    // x0 from both sources
    step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    @(posedge clk); #1;
    check("x0_we", writeEnable, 0);
    check("x0_count", fifoCount, 0);

    // Asynchronous reset with entries queued
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20);
    step(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h21);
    step(1'b1, 5'd3, 32'h3, 1'b1, 5'd22, 32'h22);
    @(posedge clk); #1;
    check("pre_rst_count", fifoCount, 3);
    rst = 1'b0;
    #1;
    check("rst_count", fifoCount, 0);
    check("rst_mask", pendingMask, 0);
    check("rst_we", writeEnable, 0);
    check("rst_addr", writeAddress, 0);
    check("rst_data", writeData, 0);
    q.delete();
    e_we = 1'b0; e_addr = '0; e_data = '0;
    aluValid = 1'b0; loadValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic; an offered load is held until accepted
    plv = 1'b0; plrd = '0; pld = '0; mdl_acc = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!plv || mdl_acc) begin
        plv  = ($urandom_range(0, 99) < 60);
        plrd = 5'($urandom_range(0, 7));
        pld  = $urandom;
      end
      step(($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
           plv, plrd, pld);
    end
    for (int n = 0; n < 8; n++) idle();
    for (int r = 0; r < 32; r++) check($sformatf("rf_x%0d", r), drf[r], mrf[r]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
